// File: rtl/modulator_pkg.sv
// Shared types for the modulator sweep scheduler.
// SWEEP_BIDIR_EN adds the down-sweep state.
package modulator_pkg;

  localparam int MOD_FW = 24;
  localparam int MOD_CW = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SWEEP    = 2'd1,
    ST_DONE     = 2'd2
`ifdef SWEEP_BIDIR_EN
    , ST_SWEEP_DN = 2'd3
`endif
  } sweep_state_t;

  function automatic logic is_sweep(input sweep_state_t s);
`ifdef SWEEP_BIDIR_EN
    return (s == ST_SWEEP) || (s == ST_SWEEP_DN);
`else
    return (s == ST_SWEEP);
`endif
  endfunction

endpackage

// File: rtl/modulator_rate_div.sv
// Clock-enable divider: registered pulse every div_i+1 cycles while enabled.
// clr_i restarts the period with an immediate pulse.
module modulator_rate_div #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [CW-1:0] div_i,
  output logic          pulse_o
);

  localparam logic [CW-1:0] ONE_CW = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // Divider next-state: a pulse accompanies every return of the count to zero
  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
    end else if (clr_i) begin
      cnt_d   = '0;
      pulse_d = 1'b1;
    end else if (cnt_q >= div_i) begin
      cnt_d   = '0;
      pulse_d = 1'b1;
    end else begin
      cnt_d = cnt_q + ONE_CW;
    end
  end

  // Divider state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/modulator_sweep_ctrl.sv
// Linear frequency-sweep scheduler driving the modulator DDS.
// Define SWEEP_BIDIR_EN for the optional up-then-down sweep (adds the bidir port).
module modulator_sweep_ctrl
  import modulator_pkg::*;
#(
  parameter int FW = MOD_FW,
  parameter int CW = MOD_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_step,
  input  logic [CW-1:0] n_steps,
  input  logic [CW-1:0] dwell,
  input  logic [CW-1:0] ce_div,
  input  logic [FW-1:0] phase_in,
`ifdef SWEEP_BIDIR_EN
  input  logic          bidir,
`endif
  output logic          ce_dds,
  output logic [FW-1:0] freqword,
  output logic [FW-1:0] phase_offset,
  output logic [CW-1:0] step_idx,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] ONE_CW = CW'(1);

  sweep_state_t  state_q, state_d;
  logic [FW-1:0] fstep_q, fstep_d;
  logic [CW-1:0] nsteps_q, nsteps_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] div_q, div_d;
  logic [FW-1:0] freq_q, freq_d;
  logic [FW-1:0] phase_q, phase_d;
  logic [CW-1:0] step_q, step_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          start_acc_s;
  logic          tick_s;
`ifdef SWEEP_BIDIR_EN
  logic          bidir_q, bidir_d;
`endif

  // Divider runs only while the next state is a sweep state, so ce_dds drops with the sweep
  modulator_rate_div #(.CW(CW)) u_rate_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (start_acc_s),
    .en_i    (is_sweep(state_d)),
    .div_i   (div_q),
    .pulse_o (tick_s)
  );

  // Sweep sequencing: start latch, dwell/step progression, abort and completion
  always_comb begin
    state_d     = state_q;
    fstep_d     = fstep_q;
    nsteps_d    = nsteps_q;
    dwell_d     = dwell_q;
    div_d       = div_q;
    freq_d      = freq_q;
    phase_d     = phase_q;
    step_d      = step_q;
    dcnt_d      = dcnt_q;
    start_acc_s = 1'b0;
`ifdef SWEEP_BIDIR_EN
    bidir_d     = bidir_q;
`endif
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            start_acc_s = 1'b1;
            fstep_d     = f_step;
            nsteps_d    = n_steps;
            dwell_d     = dwell;
            div_d       = ce_div;
            freq_d      = f_start;
            phase_d     = phase_in;
            step_d      = '0;
            dcnt_d      = '0;
`ifdef SWEEP_BIDIR_EN
            bidir_d     = bidir;
`endif
            state_d     = ST_SWEEP;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SWEEP: begin
          if (!tick_s) begin
            state_d = ST_SWEEP;
          end else if (dcnt_q < dwell_q) begin
            dcnt_d = dcnt_q + ONE_CW;
          end else if (step_q == nsteps_q) begin
`ifdef SWEEP_BIDIR_EN
            if (bidir_q && (nsteps_q != '0)) begin
              state_d = ST_SWEEP_DN;
              dcnt_d  = '0;
              step_d  = step_q - ONE_CW;
              freq_d  = freq_q - fstep_q;
            end else begin
              state_d = ST_DONE;
            end
`else
            state_d = ST_DONE;
`endif
          end else begin
            dcnt_d = '0;
            step_d = step_q + ONE_CW;
            freq_d = freq_q + fstep_q;
          end
        end
`ifdef SWEEP_BIDIR_EN
        ST_SWEEP_DN: begin
          if (!tick_s) begin
            state_d = ST_SWEEP_DN;
          end else if (dcnt_q < dwell_q) begin
            dcnt_d = dcnt_q + ONE_CW;
          end else if (step_q == '0) begin
            state_d = ST_DONE;
          end else begin
            dcnt_d = '0;
            step_d = step_q - ONE_CW;
            freq_d = freq_q - fstep_q;
          end
        end
`endif
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = is_sweep(state_d);
    done_d = (state_d == ST_DONE);
  end

  // State, configuration and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      fstep_q  <= '0;
      nsteps_q <= '0;
      dwell_q  <= '0;
      div_q    <= '0;
      freq_q   <= '0;
      phase_q  <= '0;
      step_q   <= '0;
      dcnt_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SWEEP_BIDIR_EN
      bidir_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      fstep_q  <= fstep_d;
      nsteps_q <= nsteps_d;
      dwell_q  <= dwell_d;
      div_q    <= div_d;
      freq_q   <= freq_d;
      phase_q  <= phase_d;
      step_q   <= step_d;
      dcnt_q   <= dcnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SWEEP_BIDIR_EN
      bidir_q  <= bidir_d;
`endif
    end
  end

  assign ce_dds       = tick_s;
  assign freqword     = freq_q;
  assign phase_offset = phase_q;
  assign step_idx     = step_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_modulator_sweep_ctrl.sv
// Self-checking bench for modulator_sweep_ctrl: vector table plus tick scoreboard.
module tb_modulator_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [23:0] f_start, f_step, phase_in;
  logic [15:0] n_steps, dwell, ce_div;
  logic        ce_dds, busy, done;
  logic [23:0] freqword, phase_offset;
  logic [15:0] step_idx;
`ifdef SWEEP_BIDIR_EN
  logic        bidir;
`endif

  always #5 clk = ~clk;

  modulator_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .f_start(f_start), .f_step(f_step), .n_steps(n_steps), .dwell(dwell),
    .ce_div(ce_div), .phase_in(phase_in),
`ifdef SWEEP_BIDIR_EN
    .bidir(bidir),
`endif
    .ce_dds(ce_dds), .freqword(freqword), .phase_offset(phase_offset),
    .step_idx(step_idx), .busy(busy), .done(done)
  );

  typedef struct {
    logic [23:0] f_start;
    logic [23:0] f_step;
    logic [15:0] n_steps;
    logic [15:0] dwell;
    logic [15:0] ce_div;
    logic [23:0] phase;
    logic        bidir;
    int          exp_ticks;
    logic [23:0] exp_final;
  } vec_t;

  typedef struct {
    logic [23:0] freq;
    logic [15:0] step;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_cfg(input vec_t v);
    f_start  = v.f_start;
    f_step   = v.f_step;
    n_steps  = v.n_steps;
    dwell    = v.dwell;
    ce_div   = v.ce_div;
    phase_in = v.phase;
`ifdef SWEEP_BIDIR_EN
    bidir    = v.bidir;
`endif
  endtask

  task automatic push_step(input vec_t v, input int s);
    exp_t e;
    logic [23:0] ofs;
    ofs    = 24'(s * int'(v.f_step));
    e.freq = v.f_start + ofs;
    e.step = 16'(s);
    for (int d = 0; d <= int'(v.dwell); d++) sb.push_back(e);
  endtask

  task automatic run_vec(input vec_t v);
    int   period, last, seen;
    exp_t e;
    sb.delete();
    for (int s = 0; s <= int'(v.n_steps); s++) push_step(v, s);
    if (v.bidir)
      for (int s = int'(v.n_steps) - 1; s >= 0; s--) push_step(v, s);
    period = int'(v.ce_div) + 1;
    last   = (sb.size() - 1) * period + 1;
    seen   = 0;
    @(negedge clk);
    set_cfg(v);
    start = 1'b1;
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      check("ce_dds", 32'(ce_dds), 32'((c <= last) && ((c - 1) % period == 0)));
      check("busy", 32'(busy), 32'(c <= last));
      check("done", 32'(done), 32'(c == last + 1));
      if (ce_dds) begin
        seen++;
        if (sb.size() == 0) begin
          check("sb_extra_tick", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          check("freqword", 32'(freqword), 32'(e.freq));
          check("step_idx", 32'(step_idx), 32'(e.step));
        end
      end
      if (c == 1) check("phase_offset", 32'(phase_offset), 32'(v.phase));
      if (c == 1) start = 1'b0;
      if (c == 2) begin
        // start with scrambled config mid-sweep must be ignored
        start   = 1'b1;
        f_start = ~v.f_start;
        f_step  = v.f_step + 24'h0003A5;
        n_steps = v.n_steps + 16'd5;
        dwell   = v.dwell + 16'd2;
        ce_div  = v.ce_div + 16'd1;
        phase_in = ~v.phase;
      end
      if (c == 3) start = 1'b0;
    end
    start = 1'b0;
    check("tick_total", 32'(seen), 32'(v.exp_ticks));
    check("final_freq", 32'(freqword), 32'(v.exp_final));
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'(0));
    check("idle_ce", 32'(ce_dds), 32'(0));
    check("idle_hold_freq", 32'(freqword), 32'(v.exp_final));
    check("idle_hold_phase", 32'(phase_offset), 32'(v.phase));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ce"}, 32'(ce_dds), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_freq"}, 32'(freqword), 32'(0));
    check({tag, "_phase"}, 32'(phase_offset), 32'(0));
    check({tag, "_step"}, 32'(step_idx), 32'(0));
  endtask

  initial begin
    vecs.push_back('{24'd1000, 24'd100, 16'd3, 16'd1, 16'd0, 24'h123456, 1'b0, 8, 24'd1300});
    vecs.push_back('{24'd5000, 24'd7, 16'd2, 16'd0, 16'd3, 24'hABCDEF, 1'b0, 3, 24'd5014});
    vecs.push_back('{24'hFFFF00, 24'h000200, 16'd1, 16'd0, 16'd1, 24'h000000, 1'b0, 2, 24'h000100});
    vecs.push_back('{24'h000042, 24'h000010, 16'd0, 16'd2, 16'd2, 24'h000777, 1'b0, 3, 24'h000042});
    vecs.push_back('{24'h100000, 24'h0F0F0F, 16'd4, 16'd1, 16'd1, 24'h00FACE, 1'b0, 10, 24'h4C3C3C});
`ifdef SWEEP_BIDIR_EN
    vecs.push_back('{24'd500, 24'd50, 16'd2, 16'd0, 16'd0, 24'h000321, 1'b1, 5, 24'd500});
`endif

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    set_cfg(vecs[0]);
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // abort on the third tick of the basic sweep
    @(negedge clk);
    set_cfg(vecs[0]);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_3rd_tick_ce", 32'(ce_dds), 32'(1));
    check("abort_3rd_tick_freq", 32'(freqword), 32'(1100));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_ce", 32'(ce_dds), 32'(0));
    check("abort_freq_hold", 32'(freqword), 32'(1100));
    check("abort_step_hold", 32'(step_idx), 32'(1));
    check("abort_phase_hold", 32'(phase_offset), 32'(24'h123456));
    for (int k = 0; k < 4; k++) begin
      check("abort_no_done", 32'(done), 32'(0));
      check("abort_no_ce", 32'(ce_dds), 32'(0));
      @(negedge clk);
    end

    // start together with abort in IDLE stays IDLE
    f_start = 24'h999999;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'(0));
    check("start_abort_ce", 32'(ce_dds), 32'(0));
    check("start_abort_freq", 32'(freqword), 32'(1100));
    @(negedge clk);
    check("start_abort_busy2", 32'(busy), 32'(0));

    // asynchronous reset between clock edges mid-sweep
    set_cfg(vecs[0]);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'(1));
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    check_all_zero("async_reset_hold");
    rst_n = 1'b1;
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/modulator_sweep_ctrl.md
# modulator_sweep_ctrl

Frequency-sweep scheduler that sequences the modulator DDS. It generates the DDS clock-enable at a programmable sample rate and steps the 24-bit frequency word linearly from a start value. Each frequency is held for a programmable number of samples. Sits directly upstream of the DDS: drives its `ce_in`, `freqword` and `phase_offset` inputs, and is controlled by a start/abort handshake from the host register block.

## Interface
Parameters:
- `FW`, 24, frequency/phase word width (matches DDS phase accumulator)
- `CW`, 16, width of step count, dwell count and rate divider

Ports (one clock; reset is asynchronous, active-low):
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  single-cycle request; accepted only in IDLE
- `abort`  in  1  terminate sweep; priority over `start`
- `f_start`  in  FW  initial frequency word
- `f_step`  in  FW  frequency increment per step (unsigned, modulo 2^FW)
- `n_steps`  in  CW  number of increments after the first frequency
- `dwell`  in  CW  samples per frequency minus one
- `ce_div`  in  CW  sample period in clocks minus one
- `phase_in`  in  FW  phase offset to apply for the sweep
- `ce_dds`  out  1  sample enable to DDS
- `freqword`  out  FW  frequency word to DDS
- `phase_offset`  out  FW  phase offset to DDS
- `step_idx`  out  CW  current step index
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse at normal completion

## Operation
- **States:** IDLE, SWEEP, DONE. With `SWEEP_BIDIR_EN`, SWEEP splits into SWEEP_UP and SWEEP_DN.
- **IDLE + `start` (no `abort`):**
  - Latch all configuration inputs.
  - `freqword` <= `f_start`, `phase_offset` <= `phase_in`.
  - `step_idx`, dwell counter and divider counter <= 0.
  - Next state SWEEP.
- **Rate divider:** counts 0..`ce_div` in SWEEP only. `ce_dds` is registered and high when the counter is 0. `ce_div`=0 gives `ce_dds` every cycle.
- **On each `ce_dds` tick in SWEEP:**
  - If dwell counter < `dwell`: increment the dwell counter.
  - Else, with `step_idx` = `n_steps`: next state DONE.
  - Else: dwell counter <= 0, `step_idx` += 1, `freqword` <= `freqword` + `f_step` (wraps modulo 2^FW, no saturation).
- **Sample count:** total `ce_dds` pulses per sweep = (`n_steps`+1)(`dwell`+1). `n_steps`=0 gives one frequency only.
- **DONE:** `done`=1 and `busy`=0 for one cycle, then IDLE.
- **`abort` (any state):** IDLE next cycle. No `done` pulse; `ce_dds` low from next cycle. `freqword`, `phase_offset` and `step_idx` hold their last values.
- **Other cases:**
  - `start` outside IDLE is ignored.
  - Configuration inputs changing mid-sweep have no effect.
- **Held outputs:** `freqword` and `phase_offset` hold their values in IDLE, so the DDS is frozen at the last frequency.

## Timing
- Reset value of all outputs and internal state is 0; state is IDLE.
- Reset is asynchronous: asserting `rst_n` mid-sweep forces all outputs to 0 immediately.
- `start` sampled at cycle t gives:
  - `busy`=1 from t+1;
  - first `ce_dds` at t+1;
  - `freqword` = `f_start` valid at t+1.
- A frequency update on a tick at cycle k is visible from k+1, before the next tick.
- Final tick at cycle k gives `done` at k+1 and `busy` low from k+1.
- `busy` = 1 in SWEEP states only.

## Configuration
- Macro `SWEEP_BIDIR_EN`.
- **Defined:**
  - Adds input port `bidir` (1 bit, latched at start).
  - With `bidir`=1, after the last up dwell at `step_idx`=`n_steps`, the block enters SWEEP_DN. It subtracts `f_step` and decrements `step_idx` at each dwell end, and finishes after the dwell at `step_idx`=0.
  - Total ticks = (2·`n_steps`+1)(`dwell`+1).
  - `bidir`=0 behaves as undefined.
- **Undefined:** no `bidir` port, up-sweep only.

## Structure
- Shared package `modulator_pkg`:
  - constants `MOD_FW`=24 and `MOD_CW`=16;
  - state enum `sweep_state_t`.
- One sub-module, `modulator_rate_div`: a CW-bit clock-enable divider with a synchronous clear and an enable, producing a registered single-cycle pulse.

## Test plan
- **Basic sweep:** `f_start`=1000, `f_step`=100, `n_steps`=3, `dwell`=1, `ce_div`=0; start at t → 8 `ce_dds` pulses at t+1..t+8, `freqword` 1000/1100/1200/1300 for two ticks each, `done` pulse at t+9.
- **Rate divider:** `ce_div`=3, `dwell`=0, `n_steps`=2 → `ce_dds` every 4 cycles, 3 pulses total, `freqword` updates after each.
- **Wrap-around:** `f_start`=0xFFFF00, `f_step`=0x000200, `n_steps`=1 → second `freqword` = 0x000100.
- **Abort mid-sweep:** abort at the 3rd tick → no `done`, `busy` low next cycle, `freqword` frozen; a simultaneous `start`+`abort` in IDLE stays IDLE; `start` during SWEEP is ignored.
- **Async reset:** drop `rst_n` mid-sweep between clock edges → all outputs 0 immediately; a fresh start after release runs normally.
- **Bidirectional (`SWEEP_BIDIR_EN`):** `bidir`=1, `n_steps`=2, `dwell`=0, `f_start`=500, `f_step`=50 → `freqword` sequence 500, 550, 600, 550, 500, then `done`.
